// File: rtl/sreg_piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on valid/ready and emits it
// one bit per enabled cycle with a matching shift strobe for a serial-load register.
module sreg_piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             en_i,
  output logic             bstream_o,
  output logic             shift_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_bit;

  // Bit currently presented at the outgoing end of the shadow register.
  assign out_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ready_o   = 1'b0;
    busy_o    = 1'b0;
    shift_o   = 1'b0;
    bstream_o = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          sr_d    = data_i;
          cnt_d   = CW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_o    = 1'b1;
        shift_o   = en_i;
        bstream_o = en_i & out_bit;
        if (en_i) begin
          // Shift toward the outgoing end, zero-filling the vacated bit.
          sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            done_o  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
